present_ctr_ctrl: RTL and testbench

//  Sequencer for the PRESENT-80 CTR-mode encrypt core. Takes plaintext blocks on a valid/ready stream and

---
 rtl/present_pkg.sv | 21 ++
 rtl/present_ctr_ctrl_if.sv | 25 ++
 rtl/present_ctrl_outbuf.sv | 51 +++++
 rtl/present_ctr_ctrl.sv | 158 +++++++++++++++
 tb/tb_present_ctr_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared widths, FSM state encoding and block/key types for the PRESENT-80 CTR sequencer.
package present_pkg;

  localparam int KEY_W    = 80;
  localparam int BLK_W    = 64;
  localparam int CORE_LAT = 33;
  localparam int WAIT_W   = $clog2(CORE_LAT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    IVLD  = 3'd2,
    LOAD  = 3'd3,
    WAIT  = 3'd4,
    DRAIN = 3'd5
  } ctrl_state_t;

  typedef logic [63:0] blk_t;
  typedef logic [79:0] key_t;

endpackage

// File: rtl/present_ctr_ctrl_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the CTR sequencer.
// master = host side (source and sink), slave = sequencer side.
interface present_ctr_ctrl_if;
  import present_pkg::*;

  logic in_valid;
  logic in_ready;
  blk_t in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  blk_t out_data;
  logic out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/present_ctrl_outbuf.sv
// One-entry ciphertext holding register: ld_vld captures in 1 cycle, then data/last are held
// unchanged until out_valid && out_ready; the loader only writes while the entry is empty.
module present_ctrl_outbuf
  import present_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld_vld,
  input  blk_t ld_dat,
  input  logic ld_last,
  output logic out_valid,
  input  logic out_ready,
  output blk_t out_data,
  output logic out_last
);

  logic vld_q, vld_d;
  blk_t dat_q, dat_d;
  logic last_q, last_d;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    last_d = last_q;
    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
    if (ld_vld) begin
      vld_d  = 1'b1;
      dat_d  = ld_dat;
      last_d = ld_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      last_q <= last_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign out_last  = last_q;

endmodule

// File: rtl/present_ctr_ctrl.sv
// PRESENT-80 CTR sequencer: one block in flight, in_valid->out_valid 36 cycles, at most 1 block / 37 cycles;
// source/sink stalls freeze FSM and counter. PRESENT_CTRL_BLKCNT_EN adds blk_cnt and ctr_wrap ports.
module present_ctr_ctrl
  import present_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  key_t              cfg_key,
  input  blk_t              cfg_iv,
  output logic              busy,
  present_ctr_ctrl_if.slave strm,
  output logic              core_load,
  output logic              core_load_iv,
  output blk_t              core_iv,
  output key_t              core_key,
  output blk_t              core_pt,
  input  blk_t              core_ct
`ifdef PRESENT_CTRL_BLKCNT_EN
  ,
  output logic [31:0]       blk_cnt,
  output logic              ctr_wrap
`endif
);

  ctrl_state_t         state_q, state_d;
  key_t                key_q, key_d;
  blk_t                ctr_q, ctr_d;
  blk_t                pt_q, pt_d;
  logic                last_q, last_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ob_ld;
  logic                start_acc;
  logic                drain_hs;

  assign start_acc = (state_q == IDLE) && cfg_start;
  assign drain_hs  = (state_q == DRAIN) && strm.out_valid && strm.out_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    pt_d    = pt_q;
    last_d  = last_q;
    wait_d  = wait_q;
    ob_ld   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          key_d   = cfg_key;
          ctr_d   = cfg_iv;
          state_d = RUN;
        end
      end
      RUN: begin
        if (strm.in_valid) begin
          pt_d    = strm.in_data;
          last_d  = strm.in_last;
          state_d = IVLD;
        end
      end
      IVLD: state_d = LOAD;
      LOAD: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      // wait_q reaches CORE_LAT-1 in cycle L+CORE_LAT, the cycle core_ct is valid
      WAIT: begin
        if (wait_q == WAIT_W'(CORE_LAT - 1)) begin
          ob_ld   = 1'b1;
          state_d = DRAIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          ctr_d   = ctr_q + 64'd1;
          state_d = last_q ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      pt_q    <= '0;
      last_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      pt_q    <= pt_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign strm.in_ready = (state_q == RUN);
  assign core_load_iv  = (state_q == IVLD);
  assign core_load     = (state_q == LOAD);
  assign core_iv       = ctr_q;
  assign core_key      = key_q;
  assign core_pt       = pt_q;

  present_ctrl_outbuf u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .ld_vld    (ob_ld),
    .ld_dat    (core_ct),
    .ld_last   (last_q),
    .out_valid (strm.out_valid),
    .out_ready (strm.out_ready),
    .out_data  (strm.out_data),
    .out_last  (strm.out_last)
  );

`ifdef PRESENT_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic        ctr_wrap_q, ctr_wrap_d;

  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    ctr_wrap_d = ctr_wrap_q;
    if (start_acc) begin
      blk_cnt_d  = '0;
      ctr_wrap_d = 1'b0;
    end else if (drain_hs) begin
      if (blk_cnt_q != '1) begin
        blk_cnt_d = blk_cnt_q + 32'd1;
      end
      if (ctr_q == '1) begin
        ctr_wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q  <= '0;
      ctr_wrap_q <= 1'b0;
    end else begin
      blk_cnt_q  <= blk_cnt_d;
      ctr_wrap_q <= ctr_wrap_d;
    end
  end

  assign blk_cnt  = blk_cnt_q;
  assign ctr_wrap = ctr_wrap_q;
`endif

endmodule

// File: tb/tb_present_ctr_ctrl.sv
// Randomized bench for present_ctr_ctrl with a PRESENT-80 core model and a CTR-mode scoreboard.
module tb_present_ctr_ctrl;
  import present_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cfg_start;
  key_t cfg_key;
  blk_t cfg_iv;
  logic busy;
  logic core_load, core_load_iv;
  blk_t core_iv, core_pt, core_ct;
  key_t core_key;
`ifdef PRESENT_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt;
  logic        ctr_wrap;
`endif

  present_ctr_ctrl_if strm();

  present_ctr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_key      (cfg_key),
    .cfg_iv       (cfg_iv),
    .busy         (busy),
    .strm         (strm),
    .core_load    (core_load),
    .core_load_iv (core_load_iv),
    .core_iv      (core_iv),
    .core_key     (core_key),
    .core_pt      (core_pt),
    .core_ct      (core_ct)
`ifdef PRESENT_CTRL_BLKCNT_EN
    ,
    .blk_cnt      (blk_cnt),
    .ctr_wrap     (ctr_wrap)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference PRESENT-80 encryption (31 rounds + final whitening).
  function automatic blk_t present_enc(input key_t key, input blk_t pt);
    logic [63:0] sbox;
    blk_t        s, t;
    key_t        k;
    sbox = 64'h21748FE3DA09B65C;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox[4*s[4*j +: 4] +: 4];
      t = '0;
      for (int j = 0; j < 63; j++) t[(j*16) % 63] = s[j];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox[4*k[79:76] +: 4];
      k[19:15] = k[19:15] ^ r[4:0];
    end
    return s ^ k[79:16];
  endfunction

  typedef struct {
    blk_t dat;
    logic last;
    blk_t ctr;
    int   hs_cyc;
  } exp_t;

  exp_t        exp_q[$];
  blk_t        iv_q[$];
  key_t        m_key;
  blk_t        m_ctr;
  logic [31:0] m_blk;
  logic        m_wrap;
  int          n_load   = 0;
  int          load_cyc = -1;
  int          ct_cyc   = -100;
  blk_t        last_out;

  // Core model: IV latched at load_IV, ciphertext E_key(IV)^pt valid only in cycle L+CORE_LAT.
  initial begin : core_model
    blk_t cur_iv, ct_val, pt_l;
    key_t key_l;
    logic prev_iv;
    cur_iv = '0; ct_val = '0; pt_l = '0; key_l = '0; prev_iv = 1'b0;
    core_ct = '0;
    forever begin
      @(negedge clk);
      if (core_load_iv) begin
        cur_iv = core_iv;
        chk("iv_pending", 80'(iv_q.size() > 0), 80'd1);
        if (iv_q.size() > 0) chk("core_iv", core_iv, iv_q.pop_front());
      end
      if (core_load) begin
        n_load++;
        load_cyc = cyc;
        chk("load_after_iv", prev_iv, 1'b1);
        ct_val = present_enc(core_key, cur_iv) ^ core_pt;
        ct_cyc = cyc + CORE_LAT;
        pt_l   = core_pt;
        key_l  = core_key;
      end
      if (cyc == ct_cyc - 1) begin
        chk("pt_hold", core_pt, pt_l);
        chk("key_hold", core_key, key_l);
      end
      core_ct = (cyc == ct_cyc) ? ct_val : {$urandom, $urandom};
      prev_iv = core_load_iv;
    end
  end

  task automatic start_msg(input key_t k, input blk_t iv);
    cfg_key   = k;
    cfg_iv    = iv;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_key   = {16'($urandom), $urandom, $urandom};
    cfg_iv    = {$urandom, $urandom};
    m_key  = k;
    m_ctr  = iv;
    m_blk  = '0;
    m_wrap = 1'b0;
    chk("busy_start", busy, 1'b1);
  endtask

  task automatic source(input int n, input bit zero_pt, input int gap_fix, input int gap_rnd, input bit poke);
    for (int i = 0; i < n; i++) begin
      blk_t pt;
      int   t;
      pt = zero_pt ? '0 : {$urandom, $urandom};
      if (poke) begin
        cfg_start = 1'b1;
        cfg_key   = {16'($urandom), $urandom, $urandom};
        cfg_iv    = {$urandom, $urandom};
        @(negedge clk);
        cfg_start = 1'b0;
      end
      if (i > 0) repeat (gap_fix + $urandom_range(gap_rnd, 0)) @(negedge clk);
      strm.in_valid = 1'b1;
      strm.in_data  = pt;
      strm.in_last  = (i == n - 1);
      t = 0;
      while (!strm.in_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("in_timeout", 80'(t < 3000), 80'd1);
      exp_q.push_back('{dat: present_enc(m_key, m_ctr) ^ pt, last: (i == n - 1), ctr: m_ctr, hs_cyc: cyc});
      iv_q.push_back(m_ctr);
      m_ctr = m_ctr + 64'd1;
      @(negedge clk);
      strm.in_valid = 1'b0;
      strm.in_data  = {$urandom, $urandom};
      strm.in_last  = 1'($urandom);
    end
  endtask

  task automatic sink(input int n, input int stall_first, input int stall_rnd);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   t;
      t = 0;
      e = '{dat: '0, last: 1'b0, ctr: '0, hs_cyc: 0};
      while (!strm.out_valid && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("out_timeout", 80'(t < 3000), 80'd1);
      chk("exp_pending", 80'(exp_q.size() > 0), 80'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("latency", 80'(cyc - e.hs_cyc), 80'd36);
      repeat (((i == 0) ? stall_first : 0) + $urandom_range(stall_rnd, 0)) @(negedge clk);
      chk("out_hold", strm.out_valid, 1'b1);
      chk("out_data", strm.out_data, e.dat);
      chk("out_last", strm.out_last, e.last);
      last_out = strm.out_data;
      strm.out_ready = 1'b1;
      @(negedge clk);
      strm.out_ready = 1'b0;
      if (e.ctr == '1) m_wrap = 1'b1;
      if (m_blk != 32'hFFFF_FFFF) m_blk = m_blk + 32'd1;
      chk("out_drop", strm.out_valid, 1'b0);
      if (e.last) chk("busy_drop", busy, 1'b0);
    end
  endtask

  task automatic run_msg(input key_t k, input blk_t iv, input int n, input bit zero_pt,
                         input int gap_fix, input int gap_rnd, input int stall_first,
                         input int stall_rnd, input bit poke);
    start_msg(k, iv);
    fork
      source(n, zero_pt, gap_fix, gap_rnd, poke);
      sink(n, stall_first, stall_rnd);
    join
    chk("ctr_hold", core_iv, m_ctr);
    chk("idle_in_ready", strm.in_ready, 1'b0);
`ifdef PRESENT_CTRL_BLKCNT_EN
    chk("blk_cnt", blk_cnt, m_blk);
    chk("ctr_wrap", ctr_wrap, m_wrap);
`endif
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, t, seen;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_key = '0;
    cfg_iv = '0;
    strm.in_valid = 1'b0;
    strm.in_data = '0;
    strm.in_last = 1'b0;
    strm.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", strm.in_ready, 1'b0);
    chk("rst_out_valid", strm.out_valid, 1'b0);
    chk("rst_out_last", strm.out_last, 1'b0);
    chk("rst_out_data", strm.out_data, 64'd0);
    chk("rst_core_load", {core_load, core_load_iv}, 2'b00);
    chk("rst_core_iv", core_iv, 64'd0);
    chk("rst_core_pt", core_pt, 64'd0);
    chk("rst_core_key", core_key, 80'd0);
    rst = 1'b0;
    @(negedge clk);

    run_msg('0, '0, 1, 1'b1, 0, 0, 0, 0, 1'b0);
    chk("kat_key0", last_out, 64'h5579C1387B228445);
    run_msg('1, '0, 1, 1'b1, 0, 0, 0, 0, 1'b0);
    chk("kat_key1", last_out, 64'hE72C46C0F5945049);

    run_msg('0, '0, 3, 1'b1, 0, 0, 0, 0, 1'b0);
    n0 = n_load;
    run_msg('0, '0, 3, 1'b1, 50, 0, 100, 0, 1'b0);
    chk("load_count", 80'(n_load - n0), 80'd3);

    run_msg({16'($urandom), $urandom, $urandom}, '1, 2, 1'b0, 0, 3, 0, 3, 1'b0);

    // Reset in cycle L+10 of an in-flight block.
    start_msg({16'($urandom), $urandom, $urandom}, {$urandom, $urandom});
    n0 = n_load;
    source(1, 1'b0, 0, 0, 1'b0);
    t = 0;
    while (n_load == n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("load_seen", 80'(n_load - n0), 80'd1);
    while (cyc < load_cyc + 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ct_cyc = -100;
    exp_q.delete();
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_out_valid", strm.out_valid, 1'b0);
    chk("wrst_core_pt", core_pt, 64'd0);
    chk("wrst_core_iv", core_iv, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (strm.out_valid) seen++;
    end
    chk("wrst_no_output", 80'(seen), 80'd0);
`ifdef PRESENT_CTRL_BLKCNT_EN
    chk("wrst_blk_cnt", blk_cnt, 32'd0);
`endif
    run_msg({16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0, 0, 4, 0, 4, 1'b0);

    repeat (6) begin
      run_msg({16'($urandom), $urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(4, 1), 1'b0, 0, 5, $urandom_range(5, 0), 5, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
